sram_read_sequencer: RTL and testbench

// - Drives the read port of one SRAM interface to stream a queued packet out, page by page.
// - Accepts a dequeue request (head page, tail page) from the port scheduler.
// - Issues rd_page_down/rd_page, follows the jump-table chain via rd_next_page and forwards halfwords downstream.
// - Sits between the per-port dequeue scheduler and one SRAM interface; one instance per SRAM.

---
 rtl/sram_read_sequencer_pkg.sv | 9 +
 rtl/sram_read_sequencer.sv | 135 +++++++++++++
 tb/tb_sram_read_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_read_sequencer_pkg.sv
// sram_read_sequencer_pkg: shared widths and FSM encoding for the SRAM read sequencer
package sram_read_sequencer_pkg;
    localparam int PAGE_W     = 11;
    localparam int BATCH_N    = 8;
    localparam int BEAT_W     = $clog2(BATCH_N);
    localparam int SRAM_IDX_W = 5;
    localparam int NEXT_W     = 16;
    typedef enum logic [1:0] {IDLE, WAIT, PAGE, DRAIN} state_t;
endpackage

// File: rtl/sram_read_sequencer.sv
// sram_read_sequencer: streams one queued packet out of an SRAM page by page, following the jump-table chain.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   deq_valid/deq_ready/deq_head/deq_tail   dequeue request from the port scheduler
//   out_ready                       downstream can take a full page (sampled at page start)
//   rd_page_down, rd_page           page turn pulse and page number to the SRAM interface
//   rd_xfer_data, rd_next_page, rd_ecc_code  read data, chain entry and page ECC from the SRAM
//   out_vld/out_data/out_sop/out_eop/out_ecc packet halfword stream downstream
//   chain_err                       pulse on a foreign chain entry or a runaway chain
module sram_read_sequencer
    import sram_read_sequencer_pkg::*;
#(
    parameter int SRAM_IDX  = 0,
    parameter int MAX_PAGES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              deq_valid,
    output logic              deq_ready,
    input  logic [PAGE_W-1:0] deq_head,
    input  logic [PAGE_W-1:0] deq_tail,
    input  logic              out_ready,
    output logic              rd_page_down,
    output logic [PAGE_W-1:0] rd_page,
    input  logic [15:0]       rd_xfer_data,
    input  logic [NEXT_W-1:0] rd_next_page,
    input  logic [7:0]        rd_ecc_code,
    output logic              out_vld,
    output logic [15:0]       out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [7:0]        out_ecc,
    output logic              chain_err
);
    localparam logic [SRAM_IDX_W-1:0] IDX       = SRAM_IDX_W'(SRAM_IDX);
    localparam logic [6:0]            MAX_CNT   = 7'(MAX_PAGES);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BATCH_N - 1);

    state_t            state, state_d;
    logic [BEAT_W-1:0] beat, beat_d;
    logic [PAGE_W-1:0] cur, cur_d, tail, tail_d, nxt, nxt_d, rd_page_q;
    logic [7:0]        ecc_q, ecc_d;
    logic [6:0]        cnt, cnt_d;
    logic              first, first_d, abort, abort_d;
    logic              vld_q, sop_q, eop_q;
    logic              pulse, is_tail, first_beat, last_beat;

    // beat==0 inside PAGE only occurs on a back-to-back page turn
    assign pulse      = (state == WAIT && out_ready) || (state == PAGE && beat == '0);
    assign is_tail    = cur == tail;
    assign first_beat = state == PAGE && beat == BEAT_W'(1);
    assign last_beat  = state == PAGE && beat == LAST_BEAT;

    assign deq_ready    = state == IDLE;
    assign rd_page_down = pulse;
    assign rd_page      = pulse ? cur : rd_page_q;
    assign out_vld      = vld_q;
    assign out_data     = vld_q ? rd_xfer_data : '0;
    assign out_sop      = sop_q;
    assign out_eop      = eop_q;
    // ECC is forwarded in the cycle it arrives so it covers all 8 beats of its page
    assign out_ecc      = first_beat ? rd_ecc_code : ecc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            cur       <= '0;
            tail      <= '0;
            nxt       <= '0;
            ecc_q     <= '0;
            cnt       <= '0;
            first     <= 1'b0;
            abort     <= 1'b0;
            rd_page_q <= '0;
            vld_q     <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
        end else begin
            state     <= state_d;
            beat      <= beat_d;
            cur       <= cur_d;
            tail      <= tail_d;
            nxt       <= nxt_d;
            ecc_q     <= ecc_d;
            cnt       <= cnt_d;
            first     <= first_d;
            abort     <= abort_d;
            rd_page_q <= rd_page;
            // data lags the address by one cycle: every address cycle yields a beat next cycle
            vld_q     <= pulse || state == PAGE;
            sop_q     <= pulse && first;
            eop_q     <= last_beat && (is_tail || abort);
        end
    end

    always_comb begin
        state_d   = state;
        cur_d     = cur;
        tail_d    = tail;
        nxt_d     = nxt;
        ecc_d     = ecc_q;
        cnt_d     = pulse ? ((&cnt) ? cnt : cnt + 7'd1) : cnt;
        first_d   = pulse ? 1'b0 : first;
        abort_d   = abort;
        chain_err = 1'b0;
        beat_d    = state == PAGE ? beat + 1'b1 : BEAT_W'(1);
        case (state)
            IDLE: if (deq_valid) begin
                state_d = WAIT;
                cur_d   = deq_head;
                tail_d  = deq_tail;
                cnt_d   = '0;
                first_d = 1'b1;
                abort_d = 1'b0;
            end
            WAIT: state_d = out_ready ? PAGE : WAIT;
            PAGE: begin
                if (first_beat) begin
                    nxt_d = rd_next_page[PAGE_W-1:0];
                    ecc_d = rd_ecc_code;
                    if (!is_tail && (rd_next_page[NEXT_W-1 -: SRAM_IDX_W] != IDX || cnt >= MAX_CNT)) begin
                        chain_err = 1'b1;
                        abort_d   = 1'b1;
                    end
                end
                if (last_beat) begin
                    state_d = (is_tail || abort) ? DRAIN : (out_ready ? PAGE : WAIT);
                    cur_d   = (is_tail || abort) ? cur : nxt;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sram_read_sequencer.sv
// tb_sram_read_sequencer: randomized and directed checks of the SRAM read sequencer against a chain-walking model
module tb_sram_read_sequencer;
    localparam int MAXP = 4;

    logic        clk = 0, rst_n = 0, deq_valid = 0, out_ready = 0;
    logic [10:0] deq_head = 0, deq_tail = 0;
    logic        deq_ready, rd_page_down, out_vld, out_sop, out_eop, chain_err;
    logic [10:0] rd_page;
    logic [15:0] rd_xfer_data, rd_next_page, out_data;
    logic [7:0]  rd_ecc_code, out_ecc;

    logic [15:0] nxt_tab [2048];
    logic [10:0] sp = 0;
    logic [2:0]  sb = 0;
    int cyc = 0, total = 0, bad = 0, err_n = 0, err_cyc = 0;
    logic [10:0] pg_q[$];
    int          pc_q[$], bc_q[$];
    logic [25:0] bt_q[$];

    always #5 clk = ~clk;

    sram_read_sequencer #(.SRAM_IDX(0), .MAX_PAGES(MAXP)) dut (
        .clk(clk), .rst_n(rst_n), .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_head(deq_head), .deq_tail(deq_tail), .out_ready(out_ready),
        .rd_page_down(rd_page_down), .rd_page(rd_page), .rd_xfer_data(rd_xfer_data),
        .rd_next_page(rd_next_page), .rd_ecc_code(rd_ecc_code), .out_vld(out_vld),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_ecc(out_ecc),
        .chain_err(chain_err)
    );

    function automatic logic [15:0] dat(input logic [10:0] p, input logic [2:0] b);
        return {p, 2'b10, b};
    endfunction

    function automatic logic [7:0] ecc(input logic [10:0] p);
        return 8'(int'(p) * 37 + 11);
    endfunction

    function automatic logic [40:0] outs();
        return {deq_ready, rd_page_down, rd_page, out_vld, out_sop, out_eop, out_data, out_ecc, chain_err};
    endfunction

    // SRAM read port: latches the page on a page-down, then auto-increments the beat address
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_page_down) begin
            sp <= rd_page;
            sb <= 3'd0;
        end else sb <= sb + 3'd1;
    end
    assign rd_xfer_data = dat(sp, sb);
    assign rd_next_page = nxt_tab[sp];
    assign rd_ecc_code  = ecc(sp);

    always @(negedge clk) if (rst_n) begin
        if (rd_page_down) begin pg_q.push_back(rd_page); pc_q.push_back(cyc); end
        if (out_vld) begin bt_q.push_back({out_data, out_sop, out_eop, out_ecc}); bc_q.push_back(cyc); end
        if (chain_err) begin err_n++; err_cyc = cyc; end
    end

    task automatic start(input string nm, input logic [10:0] h, input logic [10:0] t, output int acc);
        pg_q.delete(); pc_q.delete(); bt_q.delete(); bc_q.delete(); err_n = 0;
        @(posedge clk); #1;
        deq_valid = 1; deq_head = h; deq_tail = t; acc = cyc;
        total++;
        if (deq_ready !== 1'b1) begin bad++; $display("FAIL %s accept: deq_ready=%b want 1", nm, deq_ready); end
        @(posedge clk); #1;
        deq_valid = 0;
    endtask

    // mode 0: out_ready held high; 1: random out_ready; 2: out_ready low for beat 7 of page 1 and 4 more cycles
    task automatic run(input string nm, input logic [10:0] h, input logic [10:0] t, input int mode,
                       output int acc, output int rdy);
        logic [10:0] ep[$];
        logic [10:0] p;
        logic [25:0] ex;
        int eerr, n;
        start(nm, h, t, acc);
        rdy = -1;
        for (int k = 0; k < 400; k++) begin
            if (mode == 0) out_ready = 1;
            else if (mode == 1) out_ready = $urandom_range(0, 2) != 0;
            else out_ready = !(pc_q.size() > 0 && cyc >= pc_q[0] + 7 && cyc <= pc_q[0] + 11);
            if (deq_ready) begin rdy = cyc; break; end
            @(posedge clk); #1;
        end
        total++;
        if (rdy < 0) begin bad++; $display("FAIL %s timeout: deq_ready never returned", nm); end
        p = h; eerr = 0; ep.push_back(p);
        while (p != t) begin
            if (nxt_tab[p][15:11] != 5'd0 || ep.size() >= MAXP) begin eerr = 1; break; end
            p = nxt_tab[p][10:0];
            ep.push_back(p);
        end
        n = ep.size();
        total++;
        if (pg_q.size() !== n) begin bad++; $display("FAIL %s page_count: got %0d want %0d", nm, pg_q.size(), n); end
        for (int i = 0; i < pg_q.size() && i < n; i++) begin
            total++;
            if (pg_q[i] !== ep[i]) begin bad++; $display("FAIL %s page[%0d]: got %0d want %0d", nm, i, pg_q[i], ep[i]); end
        end
        total++;
        if (bt_q.size() !== 8 * n) begin bad++; $display("FAIL %s beat_count: got %0d want %0d", nm, bt_q.size(), 8 * n); end
        for (int i = 0; i < bt_q.size() && i < 8 * n; i++) begin
            ex = {dat(ep[i / 8], 3'(i % 8)), i == 0, i == 8 * n - 1, ecc(ep[i / 8])};
            total++;
            if (bt_q[i] !== ex) begin bad++; $display("FAIL %s beat[%0d] {data,sop,eop,ecc}: got %h want %h", nm, i, bt_q[i], ex); end
        end
        total++;
        if (err_n !== eerr) begin bad++; $display("FAIL %s chain_err_count: got %0d want %0d", nm, err_n, eerr); end
        if (mode == 0) begin
            for (int i = 1; i < pc_q.size(); i++) begin
                total++;
                if (pc_q[i] - pc_q[i-1] !== 8) begin bad++; $display("FAIL %s page_gap[%0d]: got %0d want 8", nm, i, pc_q[i] - pc_q[i-1]); end
            end
            if (bc_q.size() > 0 && pc_q.size() > 0) begin
                total++;
                if (bc_q[$] - bc_q[0] !== bc_q.size() - 1 || bc_q[0] !== pc_q[0] + 1) begin
                    bad++; $display("FAIL %s contiguous_beats: span %0d for %0d beats, first beat at +%0d want +1", nm, bc_q[$] - bc_q[0], bc_q.size(), bc_q[0] - pc_q[0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [40:0] want;
        want = {1'b1, 40'b0};
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (outs() !== want) begin bad++; $display("FAIL reset_outputs: got %h want %h", outs(), want); end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_single();
        int acc, rdy;
        run("single", 11'd5, 11'd5, 0, acc, rdy);
        total++;
        if (rdy - acc !== 10) begin bad++; $display("FAIL single ready_latency: got %0d want 10", rdy - acc); end
    endtask

    task automatic test_chain();
        int acc, rdy;
        nxt_tab[5] = 16'd9; nxt_tab[9] = 16'd2;
        run("chain3", 11'd5, 11'd2, 0, acc, rdy);
    endtask

    task automatic test_backpressure();
        int acc, rdy;
        nxt_tab[5] = 16'd9; nxt_tab[9] = 16'd2;
        run("backpressure", 11'd5, 11'd2, 2, acc, rdy);
        total++;
        if (pc_q.size() < 2 || bc_q.size() < 9) begin
            bad++; $display("FAIL backpressure stall: got %0d pulses %0d beats want >=2 and >=9", pc_q.size(), bc_q.size());
        end else if (pc_q[1] - pc_q[0] !== 12 || bc_q[7] !== pc_q[0] + 8 || bc_q[8] !== pc_q[1] + 1) begin
            bad++; $display("FAIL backpressure stall: gap %0d beat8 +%0d beat9-after-pulse2 %0d want 12 8 1",
                            pc_q[1] - pc_q[0], bc_q[7] - pc_q[0], bc_q[8] - pc_q[1]);
        end
    endtask

    task automatic test_bad_chain();
        int acc, rdy;
        nxt_tab[5] = 16'h2809;
        run("bad_chain", 11'd5, 11'd2, 0, acc, rdy);
        total++;
        if (pc_q.size() == 0 || err_cyc !== pc_q[0] + 1) begin bad++; $display("FAIL bad_chain err_time: got cycle %0d, pulses %0d, want page-down+1", err_cyc, pc_q.size()); end
        nxt_tab[5] = 16'd9;
    endtask

    task automatic test_runaway();
        int acc, rdy;
        nxt_tab[7] = 16'd7;
        run("runaway", 11'd7, 11'd3, 0, acc, rdy);
    endtask

    task automatic test_reset_mid();
        int acc, rdy, n;
        logic hit;
        logic [40:0] want;
        want = {1'b1, 40'b0};
        nxt_tab[5] = 16'd9; nxt_tab[9] = 16'd2;
        start("reset_mid", 11'd5, 11'd2, acc);
        hit = 0;
        for (int k = 0; k < 50; k++) begin
            out_ready = 1;
            if (pc_q.size() > 0 && cyc == pc_q[0] + 4) begin hit = 1; break; end
            @(posedge clk); #1;
        end
        total++;
        if (!hit) begin bad++; $display("FAIL reset_mid start: no page-down seen"); end
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        total++;
        if (outs() !== want) begin bad++; $display("FAIL reset_mid outputs: got %h want %h", outs(), want); end
        n = pc_q.size();
        repeat (20) @(posedge clk);
        total++;
        if (pc_q.size() !== n) begin bad++; $display("FAIL reset_mid extra_page_down: got %0d want %0d", pc_q.size(), n); end
        run("after_reset", 11'd5, 11'd2, 0, acc, rdy);
    endtask

    task automatic test_random();
        int acc, rdy, len;
        logic [10:0] pg [5];
        logic [4:0] idx;
        for (int r = 0; r < 40; r++) begin
            len = $urandom_range(1, 5);
            for (int i = 0; i < 5; i++) pg[i] = 11'($urandom_range(0, 2047));
            for (int i = 0; i + 1 < len; i++) begin
                idx = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
                nxt_tab[pg[i]] = {idx, pg[i+1]};
            end
            run("random", pg[0], pg[len-1], 1, acc, rdy);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) nxt_tab[i] = 16'd0;
        test_reset();
        test_single();
        test_chain();
        test_backpressure();
        test_bad_chain();
        test_runaway();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
